// File: rtl/shape_draw_responder.sv
// Per-shape drawing engine: answers draw_start by scanning its bounding box one pixel per clock,
// then holds draw_done until the request drops. Also scrolls its own x position on update ticks.
module shape_draw_responder #(
  parameter logic [10:0] X_START = 11'd100,
  parameter logic [10:0] Y_START = 11'd50,
  parameter int          WIDTH   = 4,
  parameter int          HEIGHT  = 4,
  parameter logic [2:0]  COLOUR  = 3'b111,
  parameter int          SHAPE   = 0,
  parameter logic [10:0] STEP    = 11'd1,
  parameter logic [10:0] X_MIN   = 11'd0,
  parameter logic [10:0] X_WRAP  = 11'd159
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        draw_start,
  input  logic        update_screen,
  output logic        draw_done,
  output logic [10:0] out_x,
  output logic [10:0] out_y,
  output logic [2:0]  out_colour,
  output logic        plot
);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  localparam logic [5:0]  COL_LAST     = 6'(WIDTH - 1);
  localparam logic [5:0]  ROW_LAST     = 6'(HEIGHT - 1);
  localparam logic [10:0] SCROLL_LIMIT = X_MIN + STEP;

  state_t      state, state_next;
  logic [10:0] pos_x, pos_x_next;
  logic [10:0] snap_x, snap_x_next;
  logic [5:0]  col, col_next;
  logic [5:0]  row, row_next;
  logic        draw_done_next;
  logic        plot_next;
  logic [10:0] out_x_next, out_y_next;
  logic [2:0]  out_colour_next;
  logic        pixel_on;

  // Spikes only light the lower-left triangle of the box; rectangles light every pixel.
  assign pixel_on = (SHAPE == 0) || (col <= row);

  always_comb begin
    state_next      = state;
    snap_x_next     = snap_x;
    col_next        = col;
    row_next        = row;
    draw_done_next  = 1'b0;
    plot_next       = 1'b0;
    out_x_next      = out_x;
    out_y_next      = out_y;
    out_colour_next = 3'd0;

    // Scrolling runs independently of drawing; the pass in flight uses snap_x.
    if (update_screen) begin
      pos_x_next = (pos_x >= SCROLL_LIMIT) ? (pos_x - STEP) : X_WRAP;
    end else begin
      pos_x_next = pos_x;
    end

    case (state)
      IDLE: begin
        if (draw_start) begin
          state_next  = DRAW;
          snap_x_next = pos_x;
          col_next    = 6'd0;
          row_next    = 6'd0;
        end
      end
      DRAW: begin
        if (!draw_start) begin
          state_next = IDLE;
        end else begin
          out_x_next      = snap_x + {5'd0, col};
          out_y_next      = Y_START + {5'd0, row};
          plot_next       = pixel_on;
          out_colour_next = pixel_on ? COLOUR : 3'd0;
          if (col == COL_LAST) begin
            col_next = 6'd0;
            row_next = row + 6'd1;
            if (row == ROW_LAST) begin
              state_next = DONE;
            end
          end else begin
            col_next = col + 6'd1;
          end
        end
      end
      DONE: begin
        if (draw_start) begin
          draw_done_next = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      pos_x      <= X_START;
      snap_x     <= X_START;
      col        <= 6'd0;
      row        <= 6'd0;
      draw_done  <= 1'b0;
      plot       <= 1'b0;
      out_x      <= 11'd0;
      out_y      <= 11'd0;
      out_colour <= 3'd0;
    end else begin
      state      <= state_next;
      pos_x      <= pos_x_next;
      snap_x     <= snap_x_next;
      col        <= col_next;
      row        <= row_next;
      draw_done  <= draw_done_next;
      plot       <= plot_next;
      out_x      <= out_x_next;
      out_y      <= out_y_next;
      out_colour <= out_colour_next;
    end
  end

endmodule

// File: tb/tb_shape_draw_responder.sv
// Bench for shape_draw_responder: a rectangle instance and a spike instance, with expected
// pixels queued by the stimulus and popped by a free-running output monitor.
module tb_shape_draw_responder;

  localparam int          R_W   = 4;
  localparam int          R_H   = 3;
  localparam logic [10:0] R_Y   = 11'd50;
  localparam logic [2:0]  R_COL = 3'b010;
  localparam int          S_W   = 3;
  localparam int          S_H   = 3;
  localparam logic [10:0] S_Y   = 11'd20;
  localparam logic [2:0]  S_COL = 3'b101;

  typedef struct {
    logic        is_done;
    logic [10:0] x;
    logic [10:0] y;
    logic [2:0]  c;
  } ev_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        r_reset, r_start, r_update, r_done, r_plot;
  logic [10:0] r_x, r_y;
  logic [2:0]  r_colour;
  logic        s_reset, s_start, s_update, s_done, s_plot;
  logic [10:0] s_x, s_y;
  logic [2:0]  s_colour;

  ev_t  q_rect[$];
  ev_t  q_spike[$];
  int   total = 0;
  int   bad   = 0;
  logic r_prev = 1'b0;
  logic s_prev = 1'b0;

  shape_draw_responder #(
    .X_START(11'd100), .Y_START(R_Y), .WIDTH(R_W), .HEIGHT(R_H), .COLOUR(R_COL),
    .SHAPE(0), .STEP(11'd1), .X_MIN(11'd0), .X_WRAP(11'd159)
  ) dut_rect (
    .clock(clock), .reset(r_reset), .draw_start(r_start), .update_screen(r_update),
    .draw_done(r_done), .out_x(r_x), .out_y(r_y), .out_colour(r_colour), .plot(r_plot)
  );

  shape_draw_responder #(
    .X_START(11'd3), .Y_START(S_Y), .WIDTH(S_W), .HEIGHT(S_H), .COLOUR(S_COL),
    .SHAPE(1), .STEP(11'd2), .X_MIN(11'd0), .X_WRAP(11'd159)
  ) dut_spike (
    .clock(clock), .reset(s_reset), .draw_start(s_start), .update_screen(s_update),
    .draw_done(s_done), .out_x(s_x), .out_y(s_y), .out_colour(s_colour), .plot(s_plot)
  );

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  // Queue the pixels one full pass should produce, in scan order, then the done marker.
  task automatic push_pass(input int sel, input logic [10:0] x0);
    ev_t e;
    int  w = (sel == 0) ? R_W : S_W;
    int  h = (sel == 0) ? R_H : S_H;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (sel == 0 || c <= r) begin
          e.is_done = 1'b0;
          e.x = x0 + 11'(c);
          e.y = ((sel == 0) ? R_Y : S_Y) + 11'(r);
          e.c = (sel == 0) ? R_COL : S_COL;
          if (sel == 0) q_rect.push_back(e);
          else          q_spike.push_back(e);
        end
      end
    end
    e.is_done = 1'b1;
    e.x = 11'd0;
    e.y = 11'd0;
    e.c = 3'd0;
    if (sel == 0) q_rect.push_back(e);
    else          q_spike.push_back(e);
  endtask

  task automatic push_pixels(input logic [10:0] x0, input int count);
    ev_t e;
    for (int c = 0; c < count; c++) begin
      e.is_done = 1'b0;
      e.x = x0 + 11'(c);
      e.y = R_Y;
      e.c = R_COL;
      q_rect.push_back(e);
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) r_start = v;
    else          s_start = v;
  endtask

  task automatic set_update(input int sel, input logic v);
    if (sel == 0) r_update = v;
    else          s_update = v;
  endtask

  // scroll_cycle: -1 none, 0 together with the request, k>0 on the k-th cycle of the pass.
  task automatic apply_stimulus(input int sel, input logic [10:0] x0, input int scroll_cycle,
                                input int hold);
    string tag   = (sel == 0) ? "rect" : "spike";
    int    area  = (sel == 0) ? R_W * R_H : S_W * S_H;
    int    exp_p = (sel == 0) ? R_W * R_H : (S_W * (S_W + 1)) / 2;
    int    cycles = 0;
    int    plots  = 0;
    int    errs   = 0;
    logic  seen   = 1'b0;
    push_pass(sel, x0);
    set_start(sel, 1'b1);
    if (scroll_cycle == 0) set_update(sel, 1'b1);
    while (!seen && cycles < 80) begin
      @(negedge clock);
      cycles++;
      set_update(sel, 1'b0);
      if (cycles == scroll_cycle) set_update(sel, 1'b1);
      if ((sel == 0) ? r_plot : s_plot) plots++;
      if ((sel == 0) ? r_done : s_done) seen = 1'b1;
    end
    check_output({tag, " done seen"}, 32'(seen), 32'd1);
    check_output({tag, " latency"}, 32'(cycles - 1), 32'(area + 1));
    check_output({tag, " plot count"}, 32'(plots), 32'(exp_p));
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      if (!((sel == 0) ? r_done : s_done) || ((sel == 0) ? r_plot : s_plot)) errs++;
    end
    check_output({tag, " held done"}, 32'(errs), 32'd0);
    set_start(sel, 1'b0);
    @(negedge clock);
    check_output({tag, " done falls"}, 32'((sel == 0) ? r_done : s_done), 32'd0);
  endtask

  task automatic mon_step(input int sel, input logic p, input logic d, input logic d_prev,
                          input logic [10:0] x, input logic [10:0] y, input logic [2:0] c);
    ev_t   e;
    string tag = (sel == 0) ? "rect" : "spike";
    int    depth = (sel == 0) ? q_rect.size() : q_spike.size();
    if (p || (d && !d_prev)) begin
      if (depth == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL %s unexpected output: got plot=%0b done=%0b x=%0d y=%0d, required none",
                 tag, p, d, x, y);
      end else begin
        e = (sel == 0) ? q_rect.pop_front() : q_spike.pop_front();
        if (p) begin
          check_output({tag, " pixel"}, {7'd0, 1'b0, x, y, c}, {7'd0, e.is_done, e.x, e.y, e.c});
        end else begin
          check_output({tag, " done order"}, 32'd1, 32'(e.is_done));
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      mon_step(0, r_plot, r_done, r_prev, r_x, r_y, r_colour);
      mon_step(1, s_plot, s_done, s_prev, s_x, s_y, s_colour);
      r_prev = r_done;
      s_prev = s_done;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int np;
    int errs;
    r_reset = 1'b1; r_start = 1'b0; r_update = 1'b0;
    s_reset = 1'b1; s_start = 1'b0; s_update = 1'b0;
    repeat (3) @(negedge clock);
    check_output("rect reset plot", 32'(r_plot), 32'd0);
    check_output("rect reset done", 32'(r_done), 32'd0);
    check_output("rect reset x", 32'(r_x), 32'd0);
    check_output("rect reset y", 32'(r_y), 32'd0);
    check_output("rect reset colour", 32'(r_colour), 32'd0);
    check_output("spike reset plot", 32'(s_plot), 32'd0);
    check_output("spike reset done", 32'(s_done), 32'd0);
    r_reset = 1'b0;
    s_reset = 1'b0;
    @(negedge clock);

    $display("[TB] rectangle pass with long hold");
    apply_stimulus(0, 11'd100, -1, 50);
    $display("[TB] scroll during a pass");
    apply_stimulus(0, 11'd100, 5, 2);
    apply_stimulus(0, 11'd99, -1, 2);

    $display("[TB] abort after four pixels");
    push_pixels(11'd99, 4);
    r_start = 1'b1;
    np = 0;
    for (int i = 0; i < 30 && np < 4; i++) begin
      @(negedge clock);
      if (r_plot) np++;
    end
    r_start = 1'b0;
    @(negedge clock);
    check_output("abort plot", 32'(r_plot), 32'd0);
    errs = 0;
    repeat (6) begin
      @(negedge clock);
      if (r_plot || r_done) errs++;
    end
    check_output("abort quiet", 32'(errs), 32'd0);

    $display("[TB] reset during a pass");
    push_pixels(11'd99, 3);
    r_start = 1'b1;
    np = 0;
    for (int i = 0; i < 30 && np < 3; i++) begin
      @(negedge clock);
      if (r_plot) np++;
    end
    r_reset = 1'b1;
    r_start = 1'b0;
    @(negedge clock);
    check_output("mid reset plot", 32'(r_plot), 32'd0);
    check_output("mid reset done", 32'(r_done), 32'd0);
    check_output("mid reset x", 32'(r_x), 32'd0);
    r_reset = 1'b0;
    @(negedge clock);
    apply_stimulus(0, 11'd100, -1, 2);

    $display("[TB] spike mask and wrap");
    apply_stimulus(1, 11'd3, -1, 2);
    s_update = 1'b1; @(negedge clock); s_update = 1'b0; @(negedge clock);
    apply_stimulus(1, 11'd1, -1, 2);
    s_update = 1'b1; @(negedge clock); s_update = 1'b0; @(negedge clock);
    s_update = 1'b1; @(negedge clock); s_update = 1'b0; @(negedge clock);
    apply_stimulus(1, 11'd157, 0, 2);
    apply_stimulus(1, 11'd155, -1, 2);

    repeat (3) @(negedge clock);
    check_output("rect queue drained", 32'(q_rect.size()), 32'd0);
    check_output("spike queue drained", 32'(q_spike.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
